// File: rtl/hll_entanglement_scanner.sv
// hll_entanglement_scanner
// Builds the vertical-entanglement matrix of a 3D HLL cell by walking all
// unordered layer pairs (z < zz) through a single AND-compare unit. Layers
// are fetched one at a time from a store with a one-cycle synchronous read.
//
// Read handshake: rd_en is a one-cycle strobe with rd_addr valid in the same
// cycle; the store returns rd_data exactly one cycle later and no back-pressure
// exists, so the scanner samples rd_data only in the cycle after each strobe
// (CAP_A after RD_A, CMP after RD_B).
module hll_entanglement_scanner #(
    parameter int NUM_LAYERS = 8,
    parameter int HASH_WIDTH = 64,
    parameter int IDX_W      = $clog2(NUM_LAYERS),
    parameter int CNT_W      = $clog2(NUM_LAYERS*(NUM_LAYERS-1)/2+1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             rd_en,
    output logic [IDX_W-1:0]                 rd_addr,
    input  logic [HASH_WIDTH-1:0]            rd_data,
    output logic [NUM_LAYERS*NUM_LAYERS-1:0] ent_matrix,
    output logic                             matrix_valid,
    output logic [CNT_W-1:0]                 pair_count,
    output logic [2:0]                       fsm_state
);

    localparam int MW = $clog2(NUM_LAYERS*NUM_LAYERS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        CAP_A = 3'd2,
        RD_B  = 3'd3,
        CMP   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                state, state_n;
    logic [IDX_W-1:0]      z, zz, z_n, zz_n;
    logic [HASH_WIDTH-1:0] reg_a;
    logic                  hit;
    logic [MW-1:0]         pos_ab, pos_ba;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fsm_state = state;

    // Compare result and the two symmetric matrix positions of the current pair
    always_comb begin
        hit    = |(reg_a & rd_data);
        pos_ab = MW'(int'(z) * NUM_LAYERS + int'(zz));
        pos_ba = MW'(int'(zz) * NUM_LAYERS + int'(z));
    end

    // Next-state and pair-index sequencing; abort overrides any running state
    always_comb begin
        state_n = state;
        z_n     = z;
        zz_n    = zz;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RD_A;
                    z_n     = '0;
                    zz_n    = IDX_W'(1);
                end
            end
            RD_A:  state_n = CAP_A;
            CAP_A: state_n = RD_B;
            RD_B:  state_n = CMP;
            CMP: begin
                if (zz < IDX_W'(NUM_LAYERS-1)) begin
                    zz_n    = zz + IDX_W'(1);
                    state_n = RD_B;
                end else if (z < IDX_W'(NUM_LAYERS-2)) begin
                    z_n     = z + IDX_W'(1);
                    zz_n    = z + IDX_W'(2);
                    state_n = RD_A;
                end else begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_n = IDLE;
        end
    end

    // State, read port, capture register and result accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            z            <= '0;
            zz           <= '0;
            reg_a        <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            ent_matrix   <= '0;
            pair_count   <= '0;
            matrix_valid <= 1'b0;
        end else begin
            state <= state_n;
            z     <= z_n;
            zz    <= zz_n;
            rd_en <= (state_n == RD_A) || (state_n == RD_B);
            if (state_n == RD_A) begin
                rd_addr <= z_n;
            end else if (state_n == RD_B) begin
                rd_addr <= zz_n;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        ent_matrix   <= '0;
                        pair_count   <= '0;
                        matrix_valid <= 1'b0;
                    end
                end
                CAP_A: reg_a <= rd_data;
                CMP: begin
                    if (hit) begin
                        ent_matrix[pos_ab] <= 1'b1;
                        ent_matrix[pos_ba] <= 1'b1;
                        pair_count         <= pair_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!abort) begin
                        matrix_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (abort && (state != IDLE)) begin
                matrix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/hll_entanglement_scanner.md
Name: hll_entanglement_scanner

Overview:
- Sequential controller that computes the vertical-entanglement matrix of a 3D HLL cell by time-multiplexing one AND-compare unit over all layer pairs.
- Layer registers are read one at a time through a synchronous read port of the layer register store. A full NUM_LAYERS x NUM_LAYERS wide-AND array is therefore not needed.
- Sits between the layer register store and downstream consumers of the entanglement matrix and pair count.

Parameters:
- NUM_LAYERS, 8, number of HLL layers; legal range >= 2.
- HASH_WIDTH, 64, bit width of one layer register.
- IDX_W, $clog2(NUM_LAYERS), width of layer index / read address.
- CNT_W, $clog2(NUM_LAYERS*(NUM_LAYERS-1)/2+1), width of the pair counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running scan.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a scan completes.
- rd_en  out  1  read strobe to the layer store.
- rd_addr  out  IDX_W  layer index being read.
- rd_data  in  HASH_WIDTH  layer register contents; valid exactly 1 cycle after rd_en.
- ent_matrix  out  NUM_LAYERS*NUM_LAYERS  bit z*NUM_LAYERS+zz = layers z and zz share a set bit.
- matrix_valid  out  1  ent_matrix holds a complete, current scan result.
- pair_count  out  CNT_W  number of entangled unordered pairs (z<zz).

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, rd_en, matrix_valid = 0; rd_addr = 0; ent_matrix = 0; pair_count = 0; reg_a = 0; z, zz = 0.
- FSM states: IDLE, RD_A, CAP_A, RD_B, CMP, DONE.
- IDLE: on start=1, load z=0 and zz=1, clear ent_matrix, pair_count and matrix_valid, then go to RD_A.
- RD_A: rd_en=1, rd_addr=z; go to CAP_A.
- CAP_A: reg_a <= rd_data; go to RD_B.
- RD_B: rd_en=1, rd_addr=zz; go to CMP.
- CMP: hit = |(reg_a & rd_data). If hit, set bits [z][zz] and [zz][z] and increment pair_count. Then take the first matching transition:
  - if zz < NUM_LAYERS-1: zz++, go to RD_B.
  - else if z < NUM_LAYERS-2: z++, zz = new z+1, go to RD_A.
  - else go to DONE.
- DONE: done=1, matrix_valid <= 1, go to IDLE. busy is still 1 in DONE.
- rd_en is 1 only in RD_A and RD_B. rd_addr holds its last value otherwise.
- Diagonal bits [z][z] are never written and stay 0. The matrix is symmetric at scan end.
- Latency:
  - Cycle 1 is the cycle after the start edge; the RD_A..CMP states occupy cycles 1 to (N-1)(N+2).
  - done is asserted in cycle (N-1)(N+2)+1: cycle 71 for N=8, cycle 5 for N=2.
  - busy falls the cycle after done.
- Partial results: ent_matrix and pair_count update incrementally during the scan. They are authoritative only while matrix_valid=1.
- start while busy is ignored, including start in the DONE cycle. No queuing.
- abort=1 in any non-IDLE state, including DONE:
  - next state is IDLE, and done is not pulsed in the following cycle;
  - matrix_valid=0;
  - ent_matrix and pair_count keep their partial values.
- abort and start together in IDLE: start wins and abort is ignored.
- Async reset mid-scan: all state and outputs clear immediately, with no done pulse. A new start is required afterwards.
- Counter: pair_count never exceeds N(N-1)/2; no wrap is possible by width choice.
- rd_data is sampled only in CAP_A and CMP; its value in all other cycles is ignored.

Test Plan:
- All layers 0, start -> done at cycle 71; ent_matrix=0; pair_count=0; matrix_valid=1; busy low in cycle 72.
- All layers 64'hFFFF_FFFF_FFFF_FFFF -> every off-diagonal bit 1, diagonal 0, pair_count=28. rd_addr sequence is 0,1,2..7,1,2..7,...,6,7.
- Layer i = 64'h1<<i (disjoint) -> ent_matrix=0, pair_count=0. Then set layers 0 and 7 to 64'h8000_0000_0000_0000 and rescan -> only bits 7 ([0][7]) and 56 ([7][0]) set; pair_count=1.
- start pulsed again at cycles 10 and 71 of a running scan -> ignored. Exactly one done at cycle 71, and the rd_en count is 7 RD_A + 28 RD_B = 35.
- abort at cycle 20 -> IDLE at cycle 21, no done, matrix_valid=0. A fresh start then completes normally in 70+1 cycles with correct results.
- rst asserted asynchronously mid-cycle during RD_B -> outputs zero before the next clock edge; FSM in IDLE; no spurious done after rst deassert.
